// File: rtl/clk_freq_checker.sv
// clk_freq_checker
//   Measures the frequency of a monitored clock by counting transitions of its
//   divide-by-2 toggle over a fixed window of i_apb_clk cycles, then checks the
//   count against a programmed target +/- tolerance.
//
// Ports
//   i_apb_clk               block clock (APB register clock)
//   i_apb_rst_n             asynchronous active-low reset
//   i_clk_chk_en            measurement enable (quasi-static)
//   i_clk_chk_target        expected edge count per window
//   i_clk_chk_tolerance     allowed absolute deviation, in edges
//   i_mon_toggle            toggle from the monitored domain (asynchronous)
//   o_clk_chk_count         edge count of the last completed window
//   o_clk_chk_in_tolerance  last completed window satisfied |count-target| <= tolerance
//   o_clk_chk_done          one-cycle pulse when a window completes
module clk_freq_checker #(
  parameter int unsigned WINDOW_CYCLES = 1000000
) (
  input  logic        i_apb_clk,
  input  logic        i_apb_rst_n,
  input  logic        i_clk_chk_en,
  input  logic [31:0] i_clk_chk_target,
  input  logic [31:0] i_clk_chk_tolerance,
  input  logic        i_mon_toggle,
  output logic [31:0] o_clk_chk_count,
  output logic        o_clk_chk_in_tolerance,
  output logic        o_clk_chk_done
);

  localparam logic [31:0] WIN_LAST = WINDOW_CYCLES - 1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic [31:0] win_q, win_d;
  logic [31:0] edges_q, edges_d;
  logic [31:0] count_q, count_d;
  logic        intol_q, intol_d;
  logic        done_q, done_d;

  logic        edge_det;
  logic [31:0] edge_inc;
  logic [32:0] cnt_ext, tgt_ext, diff;
  logic        pass;

  // Synchroniser and edge detector run regardless of state.
  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= i_mon_toggle;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Both toggle directions are edges of the monitored clock.
  assign edge_det = sync2_q ^ sync3_q;

  // Saturating count including this cycle's edge; feeds both the running
  // counter and the window-end capture so a last-cycle edge is not lost.
  assign edge_inc = (edges_q == '1) ? edges_q : edges_q + {31'd0, edge_det};

  // 33-bit absolute difference keeps target=0 / tolerance=all-ones overflow-free.
  assign cnt_ext = {1'b0, edge_inc};
  assign tgt_ext = {1'b0, i_clk_chk_target};
  assign diff    = (cnt_ext >= tgt_ext) ? (cnt_ext - tgt_ext) : (tgt_ext - cnt_ext);
  assign pass    = (diff <= {1'b0, i_clk_chk_tolerance});

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    edges_d = edges_q;
    count_d = count_q;
    intol_d = intol_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        win_d   = '0;
        edges_d = '0;
        if (i_clk_chk_en) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!i_clk_chk_en) begin
          // Disable takes priority over a coincident window end.
          state_d = IDLE;
          win_d   = '0;
          edges_d = '0;
          intol_d = 1'b0;
        end else if (win_q == WIN_LAST) begin
          count_d = edge_inc;
          intol_d = pass;
          done_d  = 1'b1;
          win_d   = '0;
          edges_d = '0;
        end else begin
          win_d   = win_q + 32'd1;
          edges_d = edge_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      edges_q <= '0;
      count_q <= '0;
      intol_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      edges_q <= edges_d;
      count_q <= count_d;
      intol_q <= intol_d;
      done_q  <= done_d;
    end
  end

  assign o_clk_chk_count        = count_q;
  assign o_clk_chk_in_tolerance = intol_q;
  assign o_clk_chk_done         = done_q;

endmodule
